lsu_unit: RTL and testbench

Load/store unit in the RV32I execute/memory boundary. It takes the byte address computed by the ALU, the store operand (rs2) and the memory opcode, then performs one data-memory transaction over a valid/ready bus. For loads it returns the lane-extracted, sign- or zero-extended value to writeback. It also flags misaligned accesses without touching memory, and serialises requests: one outstanding access at a time.

---
 rtl/rv32i_pkg.sv | 35 +++
 rtl/lsu_align.sv | 57 +++++
 rtl/lsu_unit.sv | 114 +++++++++++
 tb/tb_lsu_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I types for the load/store unit.
// Memory opcodes, LSU states and the latched request bundle.
package rv32i_pkg;

  typedef enum logic [2:0] {
    LSU_LB  = 3'd0,
    LSU_LH  = 3'd1,
    LSU_LW  = 3'd2,
    LSU_LBU = 3'd3,
    LSU_LHU = 3'd4,
    LSU_SB  = 3'd5,
    LSU_SH  = 3'd6,
    LSU_SW  = 3'd7
  } LsuOp_e;

  typedef enum logic [1:0] {
    LSU_IDLE    = 2'd0,
    LSU_REQ     = 2'd1,
    LSU_WAIT_RD = 2'd2,
    LSU_DONE    = 2'd3
  } LsuState_e;

  typedef struct packed {
    LsuOp_e      op;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        fault;
  } lsu_req_t;

  function automatic logic lsu_is_load(input LsuOp_e op);
    return (op == LSU_LB) || (op == LSU_LH) || (op == LSU_LW) ||
           (op == LSU_LBU) || (op == LSU_LHU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store lanes and enables,
// load extract and extension, and the misalignment check.
module lsu_align
  import rv32i_pkg::*;
(
  input  LsuOp_e      op,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic        misalign
);

  logic [31:0] sh;

  assign sh = rdata >> {off, 3'b000};

  always_comb begin
    be       = 4'b0000;
    wdata    = st_data;
    ld_data  = sh;
    misalign = 1'b0;
    unique case (op)
      LSU_LB: ld_data = {{24{sh[7]}}, sh[7:0]};
      LSU_LBU: ld_data = {24'h0, sh[7:0]};
      LSU_LH: begin
        ld_data  = {{16{sh[15]}}, sh[15:0]};
        misalign = off[0];
      end
      LSU_LHU: begin
        ld_data  = {16'h0, sh[15:0]};
        misalign = off[0];
      end
      LSU_LW: begin
        ld_data  = rdata;
        misalign = |off;
      end
      LSU_SB: begin
        be    = 4'b0001 << off;
        wdata = {4{st_data[7:0]}};
      end
      LSU_SH: begin
        be       = 4'b0011 << off;
        wdata    = {2{st_data[15:0]}};
        misalign = off[0];
      end
      LSU_SW: begin
        be       = 4'b1111;
        misalign = |off;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_unit.sv
// RV32I load/store unit: one outstanding data-memory access
// over a valid/ready bus, with misalign faulting.
module lsu_unit
  import rv32i_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  LsuOp_e            i_lsu_op,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_st_data,
  input  logic [4:0]        i_rd_addr,
  output logic              o_mem_valid,
  input  logic              i_mem_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [3:0]        o_mem_be,
  output logic [31:0]       o_mem_wdata,
  input  logic              i_mem_rvalid,
  input  logic [31:0]       i_mem_rdata,
  output logic              o_done,
  output logic              o_misalign,
  output logic              o_wb_valid,
  output logic [4:0]        o_wb_rd,
  output logic [31:0]       o_wb_data
);

  LsuState_e         state_q, state_d;
  lsu_req_t          req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wb_q;

  logic        idle, accept, is_ld;
  LsuOp_e      a_op;
  logic [1:0]  a_off;
  logic [3:0]  be;
  logic [31:0] wdata, ld_data;
  logic        mis;

  assign idle   = (state_q == LSU_IDLE);
  assign accept = i_req_valid && idle;
  assign is_ld  = lsu_is_load(req_q.op);

  // In IDLE the aligner checks the incoming request;
  // afterwards it steers lanes for the latched one.
  assign a_op  = idle ? i_lsu_op : req_q.op;
  assign a_off = idle ? i_addr[1:0] : addr_q[1:0];

  lsu_align u_align (
    .op      (a_op),
    .off     (a_off),
    .st_data (req_q.data),
    .rdata   (i_mem_rdata),
    .be      (be),
    .wdata   (wdata),
    .ld_data (ld_data),
    .misalign(mis)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LSU_IDLE:
        if (accept) state_d = mis ? LSU_DONE : LSU_REQ;
      LSU_REQ:
        if (i_mem_ready) state_d = is_ld ? LSU_WAIT_RD : LSU_DONE;
      LSU_WAIT_RD:
        if (i_mem_rvalid) state_d = LSU_DONE;
      LSU_DONE:
        state_d = LSU_IDLE;
      default:
        state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= LSU_IDLE;
      req_q   <= '0;
      addr_q  <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q.op    <= i_lsu_op;
        req_q.data  <= i_st_data;
        req_q.rd    <= i_rd_addr;
        req_q.fault <= mis;
        addr_q      <= i_addr;
      end
      if (state_q == LSU_WAIT_RD && i_mem_rvalid) begin
        wb_q <= ld_data;
      end
    end
  end

  assign o_req_ready = idle;
  assign o_mem_valid = (state_q == LSU_REQ);
  assign o_mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign o_mem_we    = o_mem_valid && !is_ld;
  assign o_mem_be    = o_mem_valid ? be : 4'b0000;
  assign o_mem_wdata = o_mem_valid ? wdata : 32'h0;

  assign o_done     = (state_q == LSU_DONE);
  assign o_misalign = o_done && req_q.fault;
  assign o_wb_valid = o_done && is_ld && !req_q.fault &&
                      (req_q.rd != 5'd0);
  assign o_wb_rd    = req_q.rd;
  assign o_wb_data  = wb_q;

endmodule

// File: tb/tb_lsu_unit.sv
// Directed bench for lsu_unit: stores, loads, misalign,
// back-pressure, rd=0 and reset during an outstanding load.
module tb_lsu_unit;
  import rv32i_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  LsuOp_e      lsu_op;
  logic [31:0] addr;
  logic [31:0] st_data;
  logic [4:0]  rd_addr;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        done;
  logic        misalign;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  lsu_unit #(.ADDR_W(32)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_lsu_op    (lsu_op),
    .i_addr      (addr),
    .i_st_data   (st_data),
    .i_rd_addr   (rd_addr),
    .o_mem_valid (mem_valid),
    .i_mem_ready (mem_ready),
    .o_mem_addr  (mem_addr),
    .o_mem_we    (mem_we),
    .o_mem_be    (mem_be),
    .o_mem_wdata (mem_wdata),
    .i_mem_rvalid(mem_rvalid),
    .i_mem_rdata (mem_rdata),
    .o_done      (done),
    .o_misalign  (misalign),
    .o_wb_valid  (wb_valid),
    .o_wb_rd     (wb_rd),
    .o_wb_data   (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input LsuOp_e op, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] rd);
    req_valid = 1'b1;
    lsu_op    = op;
    addr      = a;
    st_data   = d;
    rd_addr   = rd;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    lsu_op     = LSU_LB;
    addr       = '0;
    st_data    = '0;
    rd_addr    = '0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;

    step();
    step();
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_done", done, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_data", wb_data, 0);
    rst_n = 1'b1;
    step();
    chk("rst_req_ready", req_ready, 1);

    // SW, ready same cycle
    mem_ready = 1'b1;
    issue(LSU_SW, 32'h100, 32'hDEADBEEF, 5'd0);
    chk("sw_valid", mem_valid, 1);
    chk("sw_addr", mem_addr, 32'h100);
    chk("sw_we", mem_we, 1);
    chk("sw_be", mem_be, 4'b1111);
    chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
    chk("sw_done_early", done, 0);
    chk("sw_ready_busy", req_ready, 0);
    step();
    chk("sw_done", done, 1);
    chk("sw_misalign", misalign, 0);
    chk("sw_wb_valid", wb_valid, 0);
    chk("sw_valid_low", mem_valid, 0);
    step();
    chk("sw_idle", req_ready, 1);

    // SB to top byte
    issue(LSU_SB, 32'h103, 32'h000000A5, 5'd0);
    chk("sb_addr", mem_addr, 32'h100);
    chk("sb_be", mem_be, 4'b1000);
    chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
    step();
    chk("sb_done", done, 1);
    step();

    // SH to upper half
    issue(LSU_SH, 32'h12, 32'h1234BEEF, 5'd0);
    chk("sh_addr", mem_addr, 32'h10);
    chk("sh_be", mem_be, 4'b1100);
    chk("sh_wdata", mem_wdata, 32'hBEEFBEEF);
    step();
    chk("sh_done", done, 1);
    step();

    // LB sign-extend
    issue(LSU_LB, 32'h202, 32'h0, 5'd5);
    chk("lb_valid", mem_valid, 1);
    chk("lb_we", mem_we, 0);
    chk("lb_addr", mem_addr, 32'h200);
    step();
    chk("lb_wait_valid", mem_valid, 0);
    chk("lb_wait_done", done, 0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h12803456;
    step();
    mem_rvalid = 1'b0;
    chk("lb_done", done, 1);
    chk("lb_wb_valid", wb_valid, 1);
    chk("lb_wb_rd", wb_rd, 5);
    chk("lb_wb_data", wb_data, 32'hFFFFFF80);
    step();
    chk("lb_wb_pulse", wb_valid, 0);

    // LBU zero-extend
    issue(LSU_LBU, 32'h202, 32'h0, 5'd5);
    step();
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    chk("lbu_wb_valid", wb_valid, 1);
    chk("lbu_wb_data", wb_data, 32'h00000080);
    step();

    // LH misaligned
    issue(LSU_LH, 32'h201, 32'h0, 5'd6);
    chk("lh_mis_done", done, 1);
    chk("lh_mis_flag", misalign, 1);
    chk("lh_mis_valid", mem_valid, 0);
    chk("lh_mis_wb", wb_valid, 0);
    step();
    chk("lh_mis_idle", req_ready, 1);
    chk("lh_mis_valid2", mem_valid, 0);

    // LW with back-pressure
    mem_ready = 1'b0;
    issue(LSU_LW, 32'h304, 32'h0, 5'd7);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", mem_valid, 1);
      chk("bp_addr", mem_addr, 32'h304);
      step();
    end
    mem_ready = 1'b1;
    chk("bp_valid_last", mem_valid, 1);
    step();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFEF00D;
    step();
    mem_rvalid = 1'b0;
    chk("bp_wb_valid", wb_valid, 1);
    chk("bp_wb_rd", wb_rd, 7);
    chk("bp_wb_data", wb_data, 32'hCAFEF00D);
    step();

    // LH signed upper half
    issue(LSU_LH, 32'h402, 32'h0, 5'd3);
    step();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h8001ABCD;
    step();
    mem_rvalid = 1'b0;
    chk("lh_wb_data", wb_data, 32'hFFFF8001);
    step();

    // load to x0
    issue(LSU_LW, 32'h400, 32'h0, 5'd0);
    step();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h11223344;
    step();
    mem_rvalid = 1'b0;
    chk("x0_done", done, 1);
    chk("x0_wb_valid", wb_valid, 0);
    step();

    // reset while waiting for read data
    issue(LSU_LW, 32'h500, 32'h0, 5'd9);
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_valid", mem_valid, 0);
    step();
    rst_n      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h55667788;
    step();
    chk("late_rv_wb", wb_valid, 0);
    chk("late_rv_done", done, 0);
    mem_rvalid = 1'b0;
    step();
    chk("late_rv_wb2", wb_valid, 0);
    chk("late_rv_done2", done, 0);
    chk("late_rv_ready", req_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
